// File: rtl/em_queue_pkt_arbiter.sv
// rtl/em_queue_pkt_arbiter.sv - packet-granular round-robin arbiter feeding the extract-metadata stage
// Optional macro ARB_SRC_TAG_EN: stamp a one-hot source tag into m_axis_tuser on every output beat.
module em_queue_pkt_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES         = 4,
  parameter int C_TUSER_SRC_POS    = 16,
  localparam int GW                = $clog2(NUM_QUEUES),
  localparam int SW                = C_AXIS_DATA_WIDTH / 8
) (
  input  logic                                     axi_aclk,
  input  logic                                     axi_reset,
  input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_QUEUES*SW-1:0]                 s_axis_tstrb,
  input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                    s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                    s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                    s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [SW-1:0]                            m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
  output logic                                     m_axis_tvalid,
  output logic                                     m_axis_tlast,
  input  logic                                     m_axis_tready,
  input  logic [NUM_QUEUES-1:0]                    queue_en,
  output logic [GW-1:0]                            grant_idx,
  output logic                                     busy
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant;
  logic [GW-1:0]   r_rr_ptr;

  logic [NUM_QUEUES-1:0]         w_req;
  logic                          w_found;
  logic [GW-1:0]                 w_pick;
  logic [GW-1:0]                 w_next_ptr;
  logic                          w_fire;
  logic [C_AXIS_TUSER_WIDTH-1:0] w_user;

  assign w_req      = s_axis_tvalid & queue_en;
  assign w_next_ptr = (r_grant == GW'(NUM_QUEUES - 1)) ? '0 : r_grant + 1'b1;
  assign grant_idx  = r_grant;
  assign busy       = (r_state == S_BUSY);

  // Scan from the round-robin pointer so the last-served queue goes to the back.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      int idx;
      idx = (int'(r_rr_ptr) + i) % NUM_QUEUES;
      if (!w_found && w_req[idx]) begin
        w_found = 1'b1;
        w_pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    w_user = s_axis_tuser[r_grant*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
`ifdef ARB_SRC_TAG_EN
    w_user[C_TUSER_SRC_POS +: 8] = 8'(8'd1 << {r_grant, 1'b0});
`endif
  end

  // Pure mux while a packet is locked; everything is held at zero in IDLE.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (r_state == S_BUSY) begin
      m_axis_tdata           = s_axis_tdata[r_grant*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
      m_axis_tstrb           = s_axis_tstrb[r_grant*SW +: SW];
      m_axis_tuser           = w_user;
      m_axis_tvalid          = s_axis_tvalid[r_grant];
      m_axis_tlast           = s_axis_tlast[r_grant];
      s_axis_tready[r_grant] = m_axis_tready;
    end
  end

  assign w_fire = (r_state == S_BUSY) && s_axis_tvalid[r_grant] && m_axis_tready;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_fire && s_axis_tlast[r_grant]) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_em_queue_pkt_arbiter.sv
// tb/tb_em_queue_pkt_arbiter.sv - scoreboard bench for em_queue_pkt_arbiter
module tb_em_queue_pkt_arbiter;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int N  = 4;
  localparam int SP = 16;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            axi_reset = 1'b1;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N*SW-1:0] s_tstrb = '0;
  logic [N*UW-1:0] s_tuser = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tlast = '0;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [SW-1:0]   m_tstrb;
  logic [UW-1:0]   m_tuser;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_ready = 1'b1;
  logic [N-1:0]    queue_en = '1;
  logic [1:0]      grant_idx;
  logic            busy;

  always #5 clk = ~clk;

  em_queue_pkt_arbiter dut (
    .axi_aclk(clk), .axi_reset(axi_reset),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_ready),
    .queue_en(queue_en), .grant_idx(grant_idx), .busy(busy)
  );

  typedef struct packed {
    logic [1:0]    q;
    logic          l;
    logic [UW-1:0] u;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
  } beat_t;

  beat_t src_q[N][$];
  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    first_fire;
  int    hold_q = -1;
  int    hold_at = 0;
  int    hold_len = 0;
  int    en_drop_at = -1;
  bit    toggle = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [UW-1:0] tag_user(input logic [UW-1:0] u, input int q);
    logic [UW-1:0] r;
    r = u;
`ifdef ARB_SRC_TAG_EN
    r[SP +: 8] = 8'(8'd1 << (2 * q));
`endif
    return r;
  endfunction

  task automatic load_pkt(input int q, input int nb, input int nexp, input int id);
    for (int b = 0; b < nb; b++) begin
      beat_t x;
      beat_t e;
      for (int w = 0; w < DW / 32; w++) x.d[w*32 +: 32] = $urandom;
      x.d[DW-1 -: 24] = {8'(q), 8'(id), 8'(b)};
      x.s = $urandom;
      x.u = {$urandom, $urandom, $urandom, $urandom};
      x.l = (b == nb - 1);
      x.q = 2'(q);
      src_q[q].push_back(x);
      if (b < nexp) begin
        e = x;
        e.u = tag_user(x.u, q);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drive_inputs(input logic [N-1:0] hold_mask);
    for (int q = 0; q < N; q++) begin
      if (src_q[q].size() > 0) begin
        s_tdata[q*DW +: DW] = src_q[q][0].d;
        s_tstrb[q*SW +: SW] = src_q[q][0].s;
        s_tuser[q*UW +: UW] = src_q[q][0].u;
        s_tlast[q]          = src_q[q][0].l;
        s_tvalid[q]         = !hold_mask[q];
      end else begin
        s_tdata[q*DW +: DW] = '0;
        s_tstrb[q*SW +: SW] = '0;
        s_tuser[q*UW +: UW] = '0;
        s_tlast[q]          = 1'b0;
        s_tvalid[q]         = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    drive_inputs('0);
    axi_reset = 1'b1;
    m_ready   = 1'b1;
    @(negedge clk);
    #1;
    if (chk) begin
      check_eq("rst_busy", busy, 0);
      check_eq("rst_grant", grant_idx, 0);
      check_eq("rst_s_tready", s_tready, 0);
      check_eq("rst_m_tvalid", m_tvalid, 0);
      check_eq("rst_m_tlast", m_tlast, 0);
      check_eq("rst_m_tdata", m_tdata, 0);
      check_eq("rst_m_tuser", m_tuser, 0);
    end
    for (int q = 0; q < N; q++) src_q[q].delete();
    drive_inputs('0);
    @(negedge clk);
    axi_reset = 1'b0;
  endtask

  task automatic run(input int budget);
    int fired = 0;
    int cyc = 0;
    int hcnt = hold_len;
    logic [N-1:0] hm;
    first_fire = -1;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      hm = '0;
      if (hold_q >= 0 && fired == hold_at && hcnt > 0) begin
        hm[hold_q] = 1'b1;
        hcnt--;
      end
      drive_inputs(hm);
      m_ready = toggle ? ~m_ready : 1'b1;
      #1;
      if (hm != 0) begin
        check_eq("hold_tvalid", m_tvalid, 0);
        check_eq("hold_grant", grant_idx, hold_q);
        check_eq("hold_busy", busy, 1);
      end
      if (!busy) begin
        check_eq("idle_m_tvalid", m_tvalid, 0);
        check_eq("idle_s_tready", s_tready, 0);
      end else begin
        check_eq("ready_mirror", s_tready, m_ready ? (N'(1) << exp_q[0].q) : N'(0));
      end
      if (m_tvalid && m_ready) begin
        beat_t e;
        e = exp_q.pop_front();
        check_eq("beat_grant", grant_idx, e.q);
        check_eq("beat_tdata", m_tdata, e.d);
        check_eq("beat_tstrb", m_tstrb, e.s);
        check_eq("beat_tuser", m_tuser, e.u);
        check_eq("beat_tlast", m_tlast, e.l);
        if (src_q[grant_idx].size() > 0) void'(src_q[grant_idx].pop_front());
        if (first_fire < 0) first_fire = cyc;
        fired++;
        if (fired == en_drop_at) queue_en = 4'b0111;
      end
      cyc++;
    end
    if (exp_q.size() > 0) begin
      check_eq("timeout_beats_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    load_pkt(0, 1, 0, 0);
    do_reset(1'b1);

    // Lone queue: one bubble, then three beats.
    load_pkt(0, 3, 3, 1);
    run(50);
    check_eq("t1_bubble", first_fire, 1);

    // Pointer moved past Q0, so Q1 wins when both request.
    load_pkt(1, 1, 1, 2);
    load_pkt(0, 1, 1, 3);
    run(50);

    do_reset(1'b0);
    load_pkt(0, 2, 2, 4);
    load_pkt(1, 2, 2, 5);
    load_pkt(2, 2, 2, 6);
    load_pkt(3, 2, 2, 7);
    load_pkt(0, 2, 2, 8);
    run(100);

    hold_q = 1; hold_at = 1; hold_len = 2;
    load_pkt(1, 4, 4, 9);
    load_pkt(2, 2, 2, 10);
    run(100);
    hold_q = -1;

    toggle = 1'b1; en_drop_at = 1;
    load_pkt(3, 4, 4, 11);
    run(100);
    toggle = 1'b0; en_drop_at = -1; queue_en = '1;

    queue_en = 4'b1011;
    load_pkt(0, 1, 1, 12);
    load_pkt(1, 1, 1, 13);
    load_pkt(3, 1, 1, 14);
    load_pkt(0, 1, 1, 15);
    load_pkt(2, 1, 0, 16);
    run(100);
    check_eq("t5_q2_pending", src_q[2].size(), 1);
    src_q[2].delete();
    queue_en = '1;

    load_pkt(3, 4, 1, 17);
    run(50);
    do_reset(1'b1);
    load_pkt(0, 2, 2, 18);
    load_pkt(2, 2, 2, 19);
    load_pkt(3, 2, 2, 20);
    run(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
